// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the inst and data masters.
// Address phase is arbitrated combinationally, then locked until accepted.
// Responses are routed back through an in-order owner tag FIFO.
module sram_port_arbiter #(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTSTANDING);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t state, state_nxt;
  logic   prio;  // 1 = data wins the next contested cycle
  logic   grant_i, grant_d;
  logic   full, accept, push, pop, head;

  logic [OUTSTANDING-1:0] tags;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      prio  <= 1'b1;
    end else begin
      state <= state_nxt;
      // The loser of a contested accepted grant gets priority next time.
      if (accept && inst_req && data_req)
        prio <= grant_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((grant_i || grant_d) && !accept)
          state_nxt = grant_d ? LOCK_D : LOCK_I;
      end
      LOCK_I, LOCK_D: begin
        if (accept)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      LOCK_I: grant_i = 1'b1;
      LOCK_D: grant_d = 1'b1;
      default: begin
        if (inst_req && data_req) begin
          grant_d = prio;
          grant_i = ~prio;
        end else begin
          grant_i = inst_req;
          grant_d = data_req;
        end
      end
    endcase
  end

  assign full    = (count == FULL_CNT);
  assign mem_req = resetn & ~full & (grant_i | grant_d);
  assign accept  = mem_req & mem_addr_ok;

  assign mem_wr    = grant_d ? data_wr    : inst_wr;
  assign mem_size  = grant_d ? data_size  : inst_size;
  assign mem_wstrb = grant_d ? data_wstrb : inst_wstrb;
  assign mem_addr  = grant_d ? data_addr  : inst_addr;
  assign mem_wdata = grant_d ? data_wdata : inst_wdata;

  assign inst_addr_ok = accept & grant_i;
  assign data_addr_ok = accept & grant_d;

  assign push = accept;
  assign pop  = resetn & mem_data_ok & (count != '0);
  assign head = tags[rd_ptr];

  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= grant_d;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_data_ok && count == '0)
        proto_err <= 1'b1;
    end
  end
endmodule
